// File: rtl/calc_sequencer_if.sv
// ALU handshake bundle between the calculator sequencer (master) and the external ALU (slave).
interface calc_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int OPW   = 4
);
  logic [WIDTH-1:0] OperandA;
  logic [WIDTH-1:0] OperandB;
  logic [OPW-1:0]   Operation;
  logic             AluStart;
  logic             AluDone;
  logic [WIDTH-1:0] AluResult;
  logic [2:0]       AluFlags;

  modport master (
    output OperandA, OperandB, Operation, AluStart,
    input  AluDone, AluResult, AluFlags
  );

  modport slave (
    input  OperandA, OperandB, Operation, AluStart,
    output AluDone, AluResult, AluFlags
  );
endinterface

// File: rtl/calc_sequencer.sv
// Operand/operation sequencer for the switch-and-button calculator: debounced Enter steps A -> B -> op,
// then drives an external ALU via start/done with timeout, error state and chained accumulator mode.
module calc_sequencer #(
  parameter int WIDTH      = 8,
  parameter int OPW        = 4,
  parameter int DEB_CYCLES = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [WIDTH+OPW-1:0] Switchs,
  input  logic                 Enter,
  input  logic                 Clear,
  input  logic                 Chain,
  calc_sequencer_if.master     alu,
  output logic [WIDTH-1:0]     Result,
  output logic [2:0]           Flags,
  output logic [5:0]           Leds,
  output logic                 Busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_A_SET  = 3'd1,
    S_B_SET  = 3'd2,
    S_EXEC   = 3'd3,
    S_RESULT = 3'd4,
    S_ERROR  = 3'd5
  } state_e;

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [2:0]       flags_q, flags_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic [5:0]       leds_q, leds_d;
  logic [DW-1:0]    deb_cnt_q, deb_cnt_d;
  logic             armed_q, armed_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             press_s;

  function automatic logic [5:0] leds_for(input state_e s, input logic [2:0] f);
    logic [5:0] l;
    case (s)
      S_IDLE:   l = 6'b000001;
      S_A_SET:  l = 6'b000011;
      S_B_SET:  l = 6'b000111;
      S_EXEC:   l = 6'b001110;
      S_RESULT: l = {f[1], f[0], 4'b1111};
      S_ERROR:  l = 6'b101010;
      default:  l = 6'b000001;
    endcase
    return l;
  endfunction

  // Enter debounce: one press per hold, re-armed by any low sample
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    armed_d   = armed_q;
    press_s   = 1'b0;
    if (!Enter) begin
      deb_cnt_d = '0;
      armed_d   = 1'b1;
    end else if (armed_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        press_s   = 1'b1;
        armed_d   = 1'b0;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end else begin
      deb_cnt_d = deb_cnt_q;
    end
  end

  // Sequencer next state, latched values and registered output images
  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    op_d     = op_q;
    result_d = result_q;
    flags_d  = flags_q;
    tmo_d    = tmo_q;
    if (Clear) begin
      state_d  = S_IDLE;
      opa_d    = '0;
      opb_d    = '0;
      op_d     = '0;
      result_d = '0;
      flags_d  = 3'b000;
      tmo_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (press_s) begin
            opa_d   = Switchs[WIDTH-1:0];
            state_d = S_A_SET;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_A_SET: begin
          if (press_s) begin
            opb_d   = Switchs[WIDTH-1:0];
            state_d = S_B_SET;
          end else begin
            state_d = S_A_SET;
          end
        end
        S_B_SET: begin
          if (press_s) begin
            op_d    = Switchs[WIDTH+OPW-1:WIDTH];
            tmo_d   = '0;
            state_d = S_EXEC;
          end else begin
            state_d = S_B_SET;
          end
        end
        S_EXEC: begin
          // Done wins over a timeout expiring in the same cycle
          if (alu.AluDone) begin
            result_d = alu.AluResult;
            flags_d  = alu.AluFlags;
            state_d  = S_RESULT;
          end else if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
            state_d = S_ERROR;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
        S_RESULT: begin
          if (press_s) begin
            opa_d   = Chain ? result_q : Switchs[WIDTH-1:0];
            opb_d   = '0;
            state_d = S_A_SET;
          end else begin
            state_d = S_RESULT;
          end
        end
        S_ERROR: begin
          state_d = S_ERROR;
        end
        default: begin
          state_d  = S_IDLE;
          opa_d    = '0;
          opb_d    = '0;
          op_d     = '0;
          result_d = '0;
          flags_d  = 3'b000;
          tmo_d    = '0;
        end
      endcase
    end
    start_d = (state_d == S_EXEC) && (state_q != S_EXEC);
    busy_d  = (state_d == S_EXEC);
    leds_d  = leds_for(state_d, flags_d);
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      opa_q     <= '0;
      opb_q     <= '0;
      op_q      <= '0;
      result_q  <= '0;
      flags_q   <= 3'b000;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      leds_q    <= 6'b000001;
      deb_cnt_q <= '0;
      armed_q   <= 1'b1;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      op_q      <= op_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      leds_q    <= leds_d;
      deb_cnt_q <= deb_cnt_d;
      armed_q   <= armed_d;
      tmo_q     <= tmo_d;
    end
  end

  assign alu.OperandA  = opa_q;
  assign alu.OperandB  = opb_q;
  assign alu.Operation = op_q;
  assign alu.AluStart  = start_q;
  assign Result        = result_q;
  assign Flags         = flags_q;
  assign Leds          = leds_q;
  assign Busy          = busy_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: random operand/op/ALU-latency transactions plus directed corner cases.
module tb_calc_sequencer;
  localparam int WIDTH = 8;
  localparam int OPW   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [WIDTH+OPW-1:0] sw = '0;
  logic enter = 1'b0, clr = 1'b0, chain = 1'b0;
  logic [7:0] result;
  logic [2:0] flags;
  logic [5:0] leds;
  logic busy;

  calc_sequencer_if #(.WIDTH(WIDTH), .OPW(OPW)) alu_if ();

  calc_sequencer #(.WIDTH(WIDTH), .OPW(OPW), .DEB_CYCLES(2), .TIMEOUT(16)) dut (
    .clock(clk), .reset_n(rst_n), .Switchs(sw), .Enter(enter), .Clear(clr), .Chain(chain),
    .alu(alu_if.master), .Result(result), .Flags(flags), .Leds(leds), .Busy(busy)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU: add, sub, and, or, xor, pass A; flags {carry, overflow, zero}
  function automatic logic [10:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    logic [8:0] s;
    logic [7:0] r;
    logic c, v;
    c = 1'b0; v = 1'b0; s = 9'd0;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
      4'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] != b[7]) && (r[7] != a[7]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      default: r = a;
    endcase
    return {c, v, (r == 8'd0), r};
  endfunction

  // External ALU: done in EXEC cycle alu_delay+1 (cycle 1 is the AluStart cycle)
  int alu_cyc = 0;
  int alu_delay = 0;
  logic force_done = 1'b0;
  logic [10:0] alu_out = '0;
  always @(negedge clk) begin
    if (alu_if.AluStart === 1'b1) begin
      alu_cyc = 1;
      alu_out = alu_fn(alu_if.OperandA, alu_if.OperandB, alu_if.Operation);
    end else if (alu_cyc != 0 && alu_cyc < 100) begin
      alu_cyc++;
    end
    alu_if.AluDone   = force_done || (alu_cyc == alu_delay + 1);
    alu_if.AluResult = alu_out[7:0];
    alu_if.AluFlags  = alu_out[10:8];
  end

  typedef struct {
    int         kind;   // 0 result, 1 error, 2 reset/idle
    logic [7:0] res;
    logic [2:0] flg;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  // Monitor: AluStart only in the first EXEC cycle; on every end of EXEC pop and compare
  bit prev_busy = 1'b0;
  int busy_cnt = 0;
  always @(negedge clk) begin : monitor
    exp_t e;
    logic [5:0] el;
    if (busy) busy_cnt++;
    if (busy || alu_if.AluStart)
      check("alu_start_first_cycle", 32'(alu_if.AluStart), 32'(busy && busy_cnt == 1));
    if (!busy && prev_busy) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_empty: EXEC ended with no expected entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("sb_result", 32'(result), 32'(e.res));
        check("sb_flags", 32'(flags), 32'(e.flg));
        case (e.kind)
          0: el = {e.flg[1], e.flg[0], 4'b1111};
          1: el = 6'b101010;
          default: el = 6'b000001;
        endcase
        check("sb_leds", 32'(leds), 32'(el));
        if (e.kind != 2) check("sb_exec_cycles", 32'(busy_cnt), 32'(e.cyc));
      end
      busy_cnt = 0;
    end
    prev_busy = busy;
  end

  logic [7:0] m_res = 8'd0;
  logic [2:0] m_flg = 3'd0;
  bit m_in_result = 1'b0;

  task automatic press(input logic [11:0] v, input int hold);
    @(negedge clk);
    sw = v;
    enter = 1'b1;
    repeat (hold) @(negedge clk);
    enter = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_pulse();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_res = 8'd0; m_flg = 3'd0; m_in_result = 1'b0;
  endtask

  task automatic wait_not_busy();
    int k;
    for (k = 0; k < 40 && busy; k++) @(negedge clk);
    check("exec_bounded", 32'(busy), 32'(0));
    @(negedge clk);
  endtask

  task automatic run_op(input bit use_chain, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] op, input int d);
    logic [7:0] ea;
    logic [10:0] r;
    exp_t e;
    chain = use_chain;
    press({4'($urandom), a}, $urandom_range(2, 5));
    ea = (m_in_result && use_chain) ? m_res : a;
    check("opa_latch", 32'(alu_if.OperandA), 32'(ea));
    check("opb_zero", 32'(alu_if.OperandB), 32'(0));
    check("leds_a_set", 32'(leds), 32'(6'b000011));
    chain = 1'($urandom);
    press({4'($urandom), b}, $urandom_range(2, 5));
    check("opb_latch", 32'(alu_if.OperandB), 32'(b));
    check("leds_b_set", 32'(leds), 32'(6'b000111));
    alu_delay = d;
    r = alu_fn(ea, b, op);
    if (d >= 16) e = '{kind: 1, res: m_res, flg: m_flg, cyc: 16};
    else         e = '{kind: 0, res: r[7:0], flg: r[10:8], cyc: d + 1};
    exp_q.push_back(e);
    press({op, 8'($urandom)}, $urandom_range(2, 5));
    wait_not_busy();
    check("operation_latch", 32'(alu_if.Operation), 32'(op));
    if (e.kind == 1) begin
      press({4'($urandom), 8'($urandom)}, 2);
      check("error_ignores_press", 32'(leds), 32'(6'b101010));
      clear_pulse();
      check("clear_leds", 32'(leds), 32'(6'b000001));
      check("clear_opa", 32'(alu_if.OperandA), 32'(0));
      check("clear_result", 32'(result), 32'(0));
    end else begin
      m_res = r[7:0]; m_flg = r[10:8]; m_in_result = 1'b1;
    end
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    summary();
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sel, d;
    repeat (3) @(negedge clk);
    check("rst_leds", 32'(leds), 32'(6'b000001));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_start", 32'(alu_if.AluStart), 32'(0));
    check("rst_result", 32'(result), 32'(0));
    check("rst_flags", 32'(flags), 32'(0));
    check("rst_opa", 32'(alu_if.OperandA), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Debounce: a one-cycle Enter is not a press; a 10-cycle hold is exactly one
    press(12'h0AB, 1);
    check("deb_short_pulse", 32'(leds), 32'(6'b000001));
    press(12'h05C, 10);
    check("deb_held_once", 32'(leds), 32'(6'b000011));
    check("deb_opa", 32'(alu_if.OperandA), 32'(8'h5C));
    clear_pulse();
    check("deb_clear", 32'(leds), 32'(6'b000001));

    run_op(1'b0, 8'd25, 8'd17, 4'd0, 3);
    check("t1_result", 32'(result), 32'(42));
    check("t1_leds", 32'(leds), 32'(6'b001111));
    run_op(1'b1, 8'd99, 8'd8, 4'd0, 1);
    check("t2_chain_result", 32'(result), 32'(50));

    // Timeout to ERROR, then a stray done after Clear must be ignored
    run_op(1'b0, 8'd5, 8'd6, 4'd0, 16);
    @(negedge clk);
    force_done = 1'b1;
    repeat (3) @(negedge clk);
    force_done = 1'b0;
    @(negedge clk);
    check("late_done_leds", 32'(leds), 32'(6'b000001));
    check("late_done_result", 32'(result), 32'(0));

    for (int i = 0; i < 25; i++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5) d = sel;
      else if (sel == 6) d = 15;
      else if (sel == 7) d = 16;
      else d = $urandom_range(0, 3);
      run_op(1'($urandom), 8'($urandom), 8'($urandom), 4'($urandom_range(0, 5)), d);
    end

    // Clear and press on the same edge in B_SET
    run_op(1'b0, 8'd9, 8'd3, 4'd3, 0);
    press(12'h012, 2);
    press(12'h034, 2);
    check("t5_in_b_set", 32'(leds), 32'(6'b000111));
    @(negedge clk);
    sw = 12'hF11;
    enter = 1'b1;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    enter = 1'b0;
    m_res = 8'd0; m_flg = 3'd0; m_in_result = 1'b0;
    @(negedge clk);
    check("t5_leds", 32'(leds), 32'(6'b000001));
    check("t5_opa", 32'(alu_if.OperandA), 32'(0));
    check("t5_opb", 32'(alu_if.OperandB), 32'(0));
    check("t5_op", 32'(alu_if.Operation), 32'(0));

    // Asynchronous reset in the middle of EXEC
    press(12'h007, 2);
    press(12'h00B, 2);
    alu_delay = 10;
    exp_q.push_back('{kind: 2, res: 8'd0, flg: 3'd0, cyc: 0});
    press(12'h200, 2);
    check("t6_busy_before", 32'(busy), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy_async", 32'(busy), 32'(0));
    check("t6_start_async", 32'(alu_if.AluStart), 32'(0));
    check("t6_leds_async", 32'(leds), 32'(6'b000001));
    check("t6_opa_async", 32'(alu_if.OperandA), 32'(0));
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("t6_late_leds", 32'(leds), 32'(6'b000001));
    check("t6_late_result", 32'(result), 32'(0));
    check("t6_late_flags", 32'(flags), 32'(0));

    check("sb_drained", 32'(exp_q.size()), 32'(0));
    summary();
    $finish;
  end
endmodule
